// File: rtl/async_receiver_os_if.sv
// Serial receive bundle: the RxD line in, received bytes and status out.
// Optional gap-detect outputs exist only when RX_GAP_DETECT_EN is defined.
// The master modport is the receiver; the slave modport is the line driver
// plus the downstream byte consumer.
interface async_receiver_os_if;
    logic       RxD;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_framing_err;
    logic       RxD_busy;
`ifdef RX_GAP_DETECT_EN
    logic       RxD_idle;
    logic       RxD_endofpacket;
`endif

`ifdef RX_GAP_DETECT_EN
    modport master (
        input  RxD,
        output RxD_data_ready, RxD_data, RxD_framing_err, RxD_busy,
        output RxD_idle, RxD_endofpacket
    );
    modport slave (
        output RxD,
        input  RxD_data_ready, RxD_data, RxD_framing_err, RxD_busy,
        input  RxD_idle, RxD_endofpacket
    );
`else
    modport master (
        input  RxD,
        output RxD_data_ready, RxD_data, RxD_framing_err, RxD_busy
    );
    modport slave (
        output RxD,
        input  RxD_data_ready, RxD_data, RxD_framing_err, RxD_busy
    );
`endif
endinterface

// File: rtl/async_receiver_os.sv
// async_receiver_os: oversampling RS-232 receiver, 8 data bits LSB first,
// no parity, one checked stop bit. The line is synchronised, glitch-filtered
// on the oversampling tick and framed by a small state machine.
// Optional feature macro: RX_GAP_DETECT_EN adds RxD_idle / RxD_endofpacket.
module async_receiver_os #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    async_receiver_os_if.master  rx
);

    localparam int TICK_RATE = Baud * Oversampling;
    localparam int DIV       = (ClkFrequency + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W      = $clog2(Oversampling);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(Oversampling / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(Oversampling - 1);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] BIT0  = 4'd2;
    localparam logic [3:0] BIT1  = 4'd3;
    localparam logic [3:0] BIT2  = 4'd4;
    localparam logic [3:0] BIT3  = 4'd5;
    localparam logic [3:0] BIT4  = 4'd6;
    localparam logic [3:0] BIT5  = 4'd7;
    localparam logic [3:0] BIT6  = 4'd8;
    localparam logic [3:0] BIT7  = 4'd9;
    localparam logic [3:0] STOP  = 4'd10;
    localparam logic [3:0] BRK   = 4'd11;

    // Reject configurations the tick generator or sample counter cannot serve.
    generate
        if (ClkFrequency < Baud * Oversampling) begin : g_bad_clk
            $error("async_receiver_os: ClkFrequency must be >= Baud*Oversampling");
        end
        if ((Oversampling < 4) || (Oversampling > 16) ||
            ((Oversampling & (Oversampling - 1)) != 0)) begin : g_bad_os
            $error("async_receiver_os: Oversampling must be a power of 2 in 4..16");
        end
    endgenerate

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_os_tick;
    logic [1:0]       r_sync;
    logic             w_rxd_sync;
    logic [1:0]       r_filt_cnt;
    logic             r_rxd_bit;
    logic [3:0]       r_state;
    logic [OS_W-1:0]  r_os_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_data_ready;
    logic             r_framing_err;

    assign w_os_tick  = (r_div_cnt == DIV_LAST);
    assign w_rxd_sync = r_sync[1];

    // Free-running divider producing one os_tick every DIV clocks.
    always_ff @(posedge clk) begin
        if (rst || w_os_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx.RxD};
        end
    end

    // Saturating 2-bit vote on each tick; RxD_bit only flips at the rails,
    // so a low pulse shorter than three ticks never reaches the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_cnt <= 2'd3;
            r_rxd_bit  <= 1'b1;
        end else if (w_os_tick) begin
            if (w_rxd_sync && (r_filt_cnt != 2'd3)) begin
                r_filt_cnt <= r_filt_cnt + 2'd1;
            end else if (!w_rxd_sync && (r_filt_cnt != 2'd0)) begin
                r_filt_cnt <= r_filt_cnt - 2'd1;
            end
            if (r_filt_cnt == 2'd3) begin
                r_rxd_bit <= 1'b1;
            end else if (r_filt_cnt == 2'd0) begin
                r_rxd_bit <= 1'b0;
            end
        end
    end

    // Frame state machine: start validation at mid start bit, one sample per
    // bit period afterwards, stop check, and break hold-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_os_cnt      <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_data_ready  <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            r_data_ready  <= 1'b0;
            r_framing_err <= 1'b0;
            if (w_os_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!r_rxd_bit) begin
                            r_state  <= START;
                            r_os_cnt <= '0;
                        end
                    end
                    START: begin
                        if (r_os_cnt == OS_HALF) begin
                            r_os_cnt <= '0;
                            r_state  <= r_rxd_bit ? IDLE : BIT0;
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_W'(1);
                        end
                    end
                    BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt <= '0;
                            r_shift  <= {r_rxd_bit, r_shift[7:1]};
                            r_state  <= r_state + 4'd1;
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_W'(1);
                        end
                    end
                    STOP: begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt <= '0;
                            if (r_rxd_bit) begin
                                r_data       <= r_shift;
                                r_data_ready <= 1'b1;
                                r_state      <= IDLE;
                            end else begin
                                r_framing_err <= 1'b1;
                                r_state       <= BRK;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + OS_W'(1);
                        end
                    end
                    BRK: begin
                        if (r_rxd_bit) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_os_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign rx.RxD_data_ready  = r_data_ready;
    assign rx.RxD_data        = r_data;
    assign rx.RxD_framing_err = r_framing_err;
    assign rx.RxD_busy        = (r_state != IDLE);

`ifdef RX_GAP_DETECT_EN
    localparam int GAP_TICKS = 2 * Oversampling;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_FULL = GAP_W'(GAP_TICKS);
    localparam logic [GAP_W-1:0] GAP_PRE  = GAP_W'(GAP_TICKS - 1);

    logic             w_start_entry;
    logic             w_byte_done;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_idle;
    logic             r_eop;
    logic             r_got_byte;

    assign w_start_entry = w_os_tick && (r_state == IDLE) && !r_rxd_bit;
    assign w_byte_done   = w_os_tick && (r_state == STOP) &&
                           (r_os_cnt == OS_LAST) && r_rxd_bit;

    // Count idle ticks after each frame; end-of-packet fires once per burst
    // of received bytes when the line has been quiet for two bit times.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt  <= GAP_FULL;
            r_idle     <= 1'b1;
            r_eop      <= 1'b0;
            r_got_byte <= 1'b0;
        end else begin
            r_eop <= 1'b0;
            if (w_byte_done) begin
                r_got_byte <= 1'b1;
            end
            if (w_start_entry) begin
                r_gap_cnt <= '0;
                r_idle    <= 1'b0;
            end else if (w_os_tick && (r_state == IDLE) && (r_gap_cnt != GAP_FULL)) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                if (r_gap_cnt == GAP_PRE) begin
                    r_idle <= 1'b1;
                    if (r_got_byte) begin
                        r_eop      <= 1'b1;
                        r_got_byte <= 1'b0;
                    end
                end
            end
        end
    end

    assign rx.RxD_idle        = r_idle;
    assign rx.RxD_endofpacket = r_eop;
`endif

endmodule

// File: tb/tb_async_receiver_os.sv
// Directed bench for async_receiver_os at 1843200 Hz / 115200 baud / x8,
// giving two clocks per tick and sixteen clocks per bit.
module tb_async_receiver_os;

    localparam int CLK_HZ  = 1843200;
    localparam int BAUD    = 115200;
    localparam int OS      = 8;
    localparam int BIT_CLK = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    async_receiver_os_if bus();

    async_receiver_os #(
        .ClkFrequency (CLK_HZ),
        .Baud         (BAUD),
        .Oversampling (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int cyc = 0;
    int rdy_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int last_rdy_cyc = 0;
    int edge_cyc = 0;
    logic [7:0] rx_q[$];
`ifdef RX_GAP_DETECT_EN
    int eop_cnt = 0;
    int eop_cyc = 0;
    int idle_fall_cyc = 0;
    logic prev_idle = 1'b1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes away from the active edge.
    always @(negedge clk) begin
        if (bus.RxD_data_ready === 1'b1) begin
            rdy_cnt <= rdy_cnt + 1;
            rx_q.push_back(bus.RxD_data);
            last_rdy_cyc <= cyc;
        end
        if (bus.RxD_framing_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
        if ((bus.RxD_data_ready === 1'b1) && (bus.RxD_framing_err === 1'b1))
            both_cnt <= both_cnt + 1;
`ifdef RX_GAP_DETECT_EN
        if (bus.RxD_endofpacket === 1'b1) begin
            eop_cnt <= eop_cnt + 1;
            eop_cyc <= cyc;
        end
        if ((prev_idle === 1'b1) && (bus.RxD_idle === 1'b0)) idle_fall_cyc <= cyc;
        prev_idle <= bus.RxD_idle;
`endif
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        edge_cyc = cyc;
        bus.RxD = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RxD = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.RxD = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.RxD = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (bus.RxD_data_ready !== 1'b0) begin n_miss++; $display("FAIL reset_ready got=%b exp=0", bus.RxD_data_ready); end
        n_vec++; if (bus.RxD_data !== 8'h00) begin n_miss++; $display("FAIL reset_data got=%h exp=00", bus.RxD_data); end
        n_vec++; if (bus.RxD_framing_err !== 1'b0) begin n_miss++; $display("FAIL reset_ferr got=%b exp=0", bus.RxD_framing_err); end
        n_vec++; if (bus.RxD_busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%b exp=0", bus.RxD_busy); end
`ifdef RX_GAP_DETECT_EN
        n_vec++; if (bus.RxD_idle !== 1'b1) begin n_miss++; $display("FAIL reset_idle got=%b exp=1", bus.RxD_idle); end
        n_vec++; if (bus.RxD_endofpacket !== 1'b0) begin n_miss++; $display("FAIL reset_eop got=%b exp=0", bus.RxD_endofpacket); end
`endif
        bus.RxD = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        n_vec++; if (bus.RxD_busy !== 1'b0) begin n_miss++; $display("FAIL idle_busy got=%b exp=0", bus.RxD_busy); end
        n_vec++; if (rdy_cnt !== 0) begin n_miss++; $display("FAIL idle_ready_count got=%0d exp=0", rdy_cnt); end
        n_vec++; if (ferr_cnt !== 0) begin n_miss++; $display("FAIL idle_ferr_count got=%0d exp=0", ferr_cnt); end
    endtask

    task automatic test_single_byte;
        int b0, f0, lat;
        b0 = rdy_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        bus.RxD = 1'b1;
        repeat (48) @(negedge clk);
        n_vec++; if (rdy_cnt - b0 !== 1) begin n_miss++; $display("FAIL a5_strobes got=%0d exp=1", rdy_cnt - b0); end
        n_vec++; if (bus.RxD_data !== 8'hA5) begin n_miss++; $display("FAIL a5_data got=%h exp=a5", bus.RxD_data); end
        n_vec++; if (ferr_cnt - f0 !== 0) begin n_miss++; $display("FAIL a5_ferr got=%0d exp=0", ferr_cnt - f0); end
        lat = last_rdy_cyc - edge_cyc;
        n_vec++; if (!((lat >= 144) && (lat <= 184))) begin n_miss++; $display("FAIL a5_latency got=%0d exp=144..184", lat); end
    endtask

    task automatic test_back_to_back;
        int b0, f0;
        logic [7:0] exp_b [3];
        logic [7:0] got;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        b0 = rdy_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        bus.RxD = 1'b1;
        repeat (48) @(negedge clk);
        n_vec++; if (rdy_cnt - b0 !== 3) begin n_miss++; $display("FAIL b2b_strobes got=%0d exp=3", rdy_cnt - b0); end
        for (int i = 0; i < 3; i++) begin
            got = ((b0 + i) < rx_q.size()) ? rx_q[b0 + i] : 8'hxx;
            n_vec++; if (got !== exp_b[i]) begin n_miss++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, exp_b[i]); end
        end
        n_vec++; if (ferr_cnt - f0 !== 0) begin n_miss++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0); end
    endtask

    task automatic test_glitch;
        int b0, f0;
        b0 = rdy_cnt;
        f0 = ferr_cnt;
        bus.RxD = 1'b0;
        repeat (4) @(negedge clk);
        bus.RxD = 1'b1;
        repeat (BIT_CLK) @(negedge clk);
        n_vec++; if (bus.RxD_busy !== 1'b0) begin n_miss++; $display("FAIL glitch_busy got=%b exp=0", bus.RxD_busy); end
        repeat (200) @(negedge clk);
        n_vec++; if (rdy_cnt - b0 !== 0) begin n_miss++; $display("FAIL glitch_strobes got=%0d exp=0", rdy_cnt - b0); end
        n_vec++; if (ferr_cnt - f0 !== 0) begin n_miss++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0); end
        n_vec++; if (bus.RxD_data !== 8'h55) begin n_miss++; $display("FAIL glitch_data got=%h exp=55", bus.RxD_data); end
    endtask

    task automatic test_framing_break;
        int b0, f0;
        b0 = rdy_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (20 * BIT_CLK) @(negedge clk);
        n_vec++; if (bus.RxD_busy !== 1'b1) begin n_miss++; $display("FAIL break_busy got=%b exp=1", bus.RxD_busy); end
        repeat (20 * BIT_CLK) @(negedge clk);
        n_vec++; if (ferr_cnt - f0 !== 1) begin n_miss++; $display("FAIL break_ferr_count got=%0d exp=1", ferr_cnt - f0); end
        n_vec++; if (rdy_cnt - b0 !== 0) begin n_miss++; $display("FAIL break_strobes got=%0d exp=0", rdy_cnt - b0); end
        n_vec++; if (bus.RxD_data !== 8'h55) begin n_miss++; $display("FAIL break_data_held got=%h exp=55", bus.RxD_data); end
        bus.RxD = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        n_vec++; if (bus.RxD_busy !== 1'b0) begin n_miss++; $display("FAIL break_release_busy got=%b exp=0", bus.RxD_busy); end
        send_frame(8'h81, 1'b1);
        bus.RxD = 1'b1;
        repeat (48) @(negedge clk);
        n_vec++; if (rdy_cnt - b0 !== 1) begin n_miss++; $display("FAIL after_break_strobes got=%0d exp=1", rdy_cnt - b0); end
        n_vec++; if (bus.RxD_data !== 8'h81) begin n_miss++; $display("FAIL after_break_data got=%h exp=81", bus.RxD_data); end
        n_vec++; if (ferr_cnt - f0 !== 1) begin n_miss++; $display("FAIL after_break_ferr got=%0d exp=1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_frame;
        int b0, f0;
        logic [7:0] pat;
        pat = 8'hF0;
        b0 = rdy_cnt;
        f0 = ferr_cnt;
        bus.RxD = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.RxD = pat[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        n_vec++; if (bus.RxD_busy !== 1'b1) begin n_miss++; $display("FAIL midrst_busy_before got=%b exp=1", bus.RxD_busy); end
        rst = 1'b1;
        bus.RxD = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4 * BIT_CLK) @(negedge clk);
        n_vec++; if (bus.RxD_busy !== 1'b0) begin n_miss++; $display("FAIL midrst_busy_after got=%b exp=0", bus.RxD_busy); end
        n_vec++; if ((rdy_cnt - b0) + (ferr_cnt - f0) !== 0) begin n_miss++; $display("FAIL midrst_strobes got=%0d exp=0", (rdy_cnt - b0) + (ferr_cnt - f0)); end
        n_vec++; if (bus.RxD_data !== 8'h00) begin n_miss++; $display("FAIL midrst_data got=%h exp=00", bus.RxD_data); end
        send_frame(8'h42, 1'b1);
        bus.RxD = 1'b1;
        repeat (48) @(negedge clk);
        n_vec++; if (rdy_cnt - b0 !== 1) begin n_miss++; $display("FAIL midrst_next_strobes got=%0d exp=1", rdy_cnt - b0); end
        n_vec++; if (bus.RxD_data !== 8'h42) begin n_miss++; $display("FAIL midrst_next_data got=%h exp=42", bus.RxD_data); end
    endtask

`ifdef RX_GAP_DETECT_EN
    task automatic test_gap_detect;
        int e0, b0, first_edge, end_cyc, d;
        repeat (100) @(negedge clk);
        n_vec++; if (bus.RxD_idle !== 1'b1) begin n_miss++; $display("FAIL gap_idle_before got=%b exp=1", bus.RxD_idle); end
        e0 = eop_cnt;
        b0 = rdy_cnt;
        send_frame(8'h24, 1'b1);
        first_edge = edge_cyc;
        n_vec++; if (bus.RxD_idle !== 1'b0) begin n_miss++; $display("FAIL gap_idle_in_frame got=%b exp=0", bus.RxD_idle); end
        send_frame(8'h47, 1'b1);
        end_cyc = cyc;
        bus.RxD = 1'b1;
        repeat (100) @(negedge clk);
        d = idle_fall_cyc - first_edge;
        n_vec++; if (!((d >= 4) && (d <= 24))) begin n_miss++; $display("FAIL gap_idle_fall got=%0d exp=4..24", d); end
        n_vec++; if (eop_cnt - e0 !== 1) begin n_miss++; $display("FAIL gap_eop_count got=%0d exp=1", eop_cnt - e0); end
        d = eop_cyc - end_cyc;
        n_vec++; if (!((d >= 20) && (d <= 56))) begin n_miss++; $display("FAIL gap_eop_time got=%0d exp=20..56", d); end
        n_vec++; if (rdy_cnt - b0 !== 2) begin n_miss++; $display("FAIL gap_bytes got=%0d exp=2", rdy_cnt - b0); end
        n_vec++; if (bus.RxD_data !== 8'h47) begin n_miss++; $display("FAIL gap_last_byte got=%h exp=47", bus.RxD_data); end
        repeat (300) @(negedge clk);
        n_vec++; if (eop_cnt - e0 !== 1) begin n_miss++; $display("FAIL gap_eop_quiet got=%0d exp=1", eop_cnt - e0); end
        n_vec++; if (bus.RxD_idle !== 1'b1) begin n_miss++; $display("FAIL gap_idle_after got=%b exp=1", bus.RxD_idle); end
    endtask
`endif

    initial begin
        bus.RxD = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing_break();
        test_reset_mid_frame();
`ifdef RX_GAP_DETECT_EN
        test_gap_detect();
`endif
        n_vec++; if (both_cnt !== 0) begin n_miss++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
